fetch_decoder: RTL

Prefetching instruction front end for the 16-bit accumulator CPU. It fetches bytes from program memory into a parametrised prefetch buffer and assembles variable-length instructions: one byte when bit 7 of the opcode byte is 0, two bytes otherwise. Each assembled instruction is presented with its PC, length and pre-decoded immediate on a valid/ready output register. It sits between the memory interface and the execute stage's combinational decoder, and supports pipeline flush on taken branch, call or return.

---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/prefetch_fifo.sv | 58 +++++
 rtl/fetch_decoder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit accumulator CPU front end and execute decoder.
// Holds opcode constants, group masks, the fetch FSM states and the length/immediate helpers.
package cpu_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_HALT   = 8'h01;
  localparam logic [7:0] OP_RET    = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_AND    = 8'h05;
  localparam logic [7:0] OP_OR     = 8'h06;
  localparam logic [7:0] OP_XOR    = 8'h07;
  localparam logic [7:0] OP_SHL    = 8'h08;
  localparam logic [7:0] OP_SHR    = 8'h09;
  localparam logic [7:0] OP_SET_DP = 8'h0A;

  localparam logic [15:0] GRP_MASK_BR  = 16'hF800;
  localparam logic [15:0] GRP_MASK_TOP = 16'hC000;
  localparam logic [15:0] GRP_MASK_SEL = 16'h0700;

  localparam logic [15:0] GRP_LOAD   = 16'h8000;
  localparam logic [15:0] GRP_BRANCH = 16'hC000;
  localparam logic [15:0] GRP_CALL   = 16'hD000;
  localparam logic [15:0] GRP_IF     = 16'hF000;

  typedef enum logic [1:0] {FS_IDLE, FS_REQ, FS_DISCARD} fetch_state_e;

  typedef struct packed {
    logic [15:0] inst;
    logic [1:0]  bytes;
    logic [15:0] imm;
  } dec_inst_t;

  function automatic logic [1:0] inst_len(input logic [7:0] op);
    return op[7] ? 2'd2 : 2'd1;
  endfunction

  // Immediate pre-decode; 1-byte opcodes have bit 15 clear so only the default applies.
  function automatic logic [15:0] pre_imm(input logic [15:0] inst);
    logic two;
    two = inst[15];
    if ((inst & GRP_MASK_BR) == GRP_BRANCH || (inst & GRP_MASK_BR) == GRP_CALL)
      return {{5{inst[10]}}, inst[10:0]};
    else if (two && (inst & GRP_MASK_SEL) == 16'h0000)
      return {8'h00, inst[7:0]};
    else if (two && (inst & GRP_MASK_SEL) == 16'h0100)
      return {inst[7:0], 8'h00};
    else if (two && inst[10])
      return {8'h00, inst[7:0]};
    else
      return 16'h0000;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Byte FIFO for the instruction prefetcher: one push, pop of 0/1/2, two-entry peek.
// Popping the byte being pushed in the same cycle is allowed; the caller bypasses its data.
module prefetch_fifo #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic [1:0]    pop,
  output logic [7:0]    peek0,
  output logic [7:0]    peek1,
  output logic [CW-1:0] count
);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clr) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      wr_d  = wr_q + PW'(push);
      rd_d  = rd_q + PW'(pop);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_q] <= push_data;
  end

  assign peek0 = mem_q[rd_q];
  assign peek1 = mem_q[rd_q + PW'(1)];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_decoder.sv
// Prefetching front end: fetches bytes into a small FIFO and assembles 1/2-byte
// instructions with PC, length and pre-decoded immediate behind a valid/ready register.
module fetch_decoder
  import cpu_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [1:0]        out_bytes,
  output logic [15:0]       out_imm
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] decode_pc_q, decode_pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  dec_inst_t         out_q, out_d;

  logic [7:0]    peek0, peek1, head0, head1;
  logic [CW-1:0] count, avail, count_nx;
  logic [1:0]    len, pop;
  logic          push_ok, fire;
  logic [15:0]   new_inst;

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (push_ok),
    .push_data (mem_data),
    .pop       (pop),
    .peek0     (peek0),
    .peek1     (peek1),
    .count     (count)
  );

  // Bytes arriving this cycle are visible to assembly, giving ack-to-valid of one cycle.
  always_comb begin
    push_ok  = (state_q == FS_REQ) && mem_ack && !flush;
    avail    = count + CW'(push_ok);
    head0    = (count != '0)       ? peek0 : mem_data;
    head1    = (count >= CW'(2))   ? peek1 : mem_data;
    len      = inst_len(head0);
    new_inst = (len == 2'd2) ? {head0, head1} : {head0, 8'h00};
    fire     = !flush && (!out_valid_q || out_ready) && (avail >= CW'(len));
    pop      = fire ? len : 2'd0;
    count_nx = avail - CW'(pop);
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      FS_IDLE: if (count < CW'(DEPTH)) state_d = FS_REQ;
      FS_REQ: begin
        if (mem_ack) begin
          fetch_pc_d = fetch_pc_q + ADDR_W'(1);
          state_d    = (count_nx < CW'(DEPTH)) ? FS_REQ : FS_IDLE;
        end
      end
      FS_DISCARD: if (mem_ack) state_d = FS_IDLE;
      default: state_d = FS_IDLE;
    endcase
    if (flush) begin
      fetch_pc_d = flush_pc;
      unique case (state_q)
        FS_IDLE: state_d = FS_REQ;
        default: state_d = mem_ack ? FS_IDLE : FS_DISCARD;
      endcase
    end
    // The discarded request must keep its original address until acked.
    mem_addr_d = (state_d == FS_DISCARD) ? mem_addr_q : fetch_pc_d;
    mem_req_d  = (state_d != FS_IDLE);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_d       = out_q;
    decode_pc_d = decode_pc_q;
    if (flush) begin
      out_valid_d = 1'b0;
      decode_pc_d = flush_pc;
    end else if (fire) begin
      out_valid_d = 1'b1;
      out_pc_d    = decode_pc_q;
      out_d.inst  = new_inst;
      out_d.bytes = len;
      out_d.imm   = pre_imm(new_inst);
      decode_pc_d = decode_pc_q + ADDR_W'(len);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FS_IDLE;
      fetch_pc_q  <= RESET_PC;
      decode_pc_q <= RESET_PC;
      mem_addr_q  <= RESET_PC;
      mem_req_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= RESET_PC;
      out_q       <= '{inst: 16'h0000, bytes: 2'd1, imm: 16'h0000};
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      decode_pc_q <= decode_pc_d;
      mem_addr_q  <= mem_addr_d;
      mem_req_q   <= mem_req_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_q       <= out_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_inst  = out_q.inst;
  assign out_bytes = out_q.bytes;
  assign out_imm   = out_q.imm;

endmodule
